// File: rtl/iwt_pkg.sv
// rtl/iwt_pkg.sv - shared types, limits and saturation helper for the inverse Haar decoder
package iwt_pkg;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_D = 2'd1,
        EMIT1  = 2'd2
    } state_t;

    localparam int DATA_WIDTH = 8;
    localparam int MAX_WIDTH  = 32;

    localparam int SAT_MAX = (1 << (DATA_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(1 << (DATA_WIDTH - 1));

    // Wide enough to hold any WIDTH+1 bit sum for WIDTH up to MAX_WIDTH.
    typedef logic signed [MAX_WIDTH:0] wide_t;

    function automatic wide_t sat_max(input int width);
        return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_min(input int width);
        return -(wide_t'(1) <<< (width - 1));
    endfunction

    function automatic wide_t saturate(input wide_t v, input int width);
        if (v > sat_max(width)) begin
            return sat_max(width);
        end
        if (v < sat_min(width)) begin
            return sat_min(width);
        end
        return v;
    endfunction

endpackage

// File: rtl/strobe_sync.sv
// rtl/strobe_sync.sv - pin strobe synchronizer with single-cycle rising-edge pulse
module strobe_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic [STAGES-1:0] sync_q;
    logic              delay_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            delay_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], async_in};
            delay_q <= sync_q[STAGES-1];
        end
    end

    // A pin held high keeps delay_q high, so only the first synchronized cycle fires.
    assign pulse = sync_q[STAGES-1] & ~delay_q;

endmodule

// File: rtl/inverse_wavelet_transform.sv
// rtl/inverse_wavelet_transform.sv - single-level Haar reconstruction from pin-clocked (a, d) pairs
module inverse_wavelet_transform
    import iwt_pkg::*;
#(
    parameter int WIDTH       = DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_data_clk,
    input  logic [WIDTH-1:0] i_coeff,
    input  logic             i_realign,
    output logic [WIDTH-1:0] o_sample,
    output logic             o_sample_strobe,
    output logic             o_overflow,
    output logic             o_active
);

    state_t state, state_next;

    logic                    capture;
    logic signed [WIDTH-1:0] coeff;
    logic signed [WIDTH-1:0] a_q;
    logic signed [WIDTH-1:0] s0_q;
    logic signed [WIDTH-1:0] s1_q;
    logic                    ov0_q;
    logic                    ov1_q;
    logic                    pair_valid;

    logic                    load_a;
    logic                    load_pair;
    logic                    emit0;
    logic                    emit1;

    logic signed [WIDTH:0]   sum;
    logic signed [WIDTH:0]   diff;
    wide_t                   sum_w;
    wide_t                   diff_w;
    wide_t                   sum_sat;
    wide_t                   diff_sat;

    strobe_sync #(
        .STAGES (SYNC_STAGES)
    ) u_strobe_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (i_data_clk),
        .pulse    (capture)
    );

    assign coeff    = signed'(i_coeff);
    assign sum      = (WIDTH+1)'(a_q) + (WIDTH+1)'(coeff);
    assign diff     = (WIDTH+1)'(a_q) - (WIDTH+1)'(coeff);
    assign sum_w    = wide_t'(sum);
    assign diff_w   = wide_t'(diff);
    assign sum_sat  = saturate(sum_w, WIDTH);
    assign diff_sat = saturate(diff_w, WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_A;
        end else begin
            state <= state_next;
        end
    end

    // WAIT_D spends one extra cycle with pair_valid set so x0 lands one clk after the d capture.
    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_pair  = 1'b0;
        emit0      = 1'b0;
        emit1      = 1'b0;
        if (i_realign) begin
            state_next = WAIT_A;
            if (capture) begin
                load_a     = 1'b1;
                state_next = WAIT_D;
            end
        end else begin
            unique case (state)
                WAIT_A: begin
                    if (capture) begin
                        load_a     = 1'b1;
                        state_next = WAIT_D;
                    end
                end
                WAIT_D: begin
                    if (pair_valid) begin
                        emit0      = 1'b1;
                        state_next = EMIT1;
                    end else if (capture) begin
                        load_pair  = 1'b1;
                    end
                end
                EMIT1: begin
                    emit1      = 1'b1;
                    state_next = WAIT_A;
                end
                default: begin
                    state_next = WAIT_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q             <= '0;
            s0_q            <= '0;
            s1_q            <= '0;
            ov0_q           <= 1'b0;
            ov1_q           <= 1'b0;
            pair_valid      <= 1'b0;
            o_sample        <= '0;
            o_sample_strobe <= 1'b0;
            o_overflow      <= 1'b0;
        end else begin
            o_sample_strobe <= 1'b0;
            if (i_realign) begin
                a_q        <= '0;
                pair_valid <= 1'b0;
            end
            if (load_a) begin
                a_q <= coeff;
            end
            if (load_pair) begin
                s0_q       <= sum_sat[WIDTH-1:0];
                s1_q       <= diff_sat[WIDTH-1:0];
                ov0_q      <= (sum_sat != sum_w);
                ov1_q      <= (diff_sat != diff_w);
                pair_valid <= 1'b1;
            end
            if (emit0) begin
                o_sample        <= s0_q;
                o_sample_strobe <= 1'b1;
                pair_valid      <= 1'b0;
                if (ov0_q) begin
                    o_overflow <= 1'b1;
                end
            end
            if (emit1) begin
                o_sample        <= s1_q;
                o_sample_strobe <= 1'b1;
                if (ov1_q) begin
                    o_overflow <= 1'b1;
                end
            end
        end
    end

    assign o_active = (state != WAIT_A);

endmodule
